// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID, ID/EX latches.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks a fetched instruction while
// the downstream latch cannot accept it.
module fetch_hold_buf
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] ir_d,
  input  logic [31:0] pc_d,
  output logic [31:0] ir_buf,
  output logic [31:0] pc_buf
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_buf <= NOP;
      pc_buf <= RESET_PC;
    end else if (clear) begin
      ir_buf <= NOP;
      pc_buf <= RESET_PC;
    end else if (load) begin
      ir_buf <= ir_d;
      pc_buf <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 instruction-fetch stage: owns the fetch PC, runs the
// imem request/ready handshake and feeds the IF/ID latch.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCOUT,
  output logic [31:0] IR,
  output logic        fetch_valid,
  output logic        fetch_busy
);

  fetch_state_t state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr, req_d;
  logic [31:0] ir_buf, pc_buf;
  logic [31:0] tgt;
  logic accept, redir;
  logic buf_load, buf_clear;

  assign accept = EN & ~stall & ~redirect;
  assign redir  = EN & redirect;
  assign tgt    = align_pc(redirect_pc);

  fetch_hold_buf #(
    .RESET_PC(RESET_PC),
    .NOP     (NOP)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .ir_d  (imem_rdata),
    .pc_d  (req_addr),
    .ir_buf(ir_buf),
    .pc_buf(pc_buf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_d;
      pc_q     <= pc_d;
      req_addr <= req_d;
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc_q;
    req_d     = req_addr;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    unique case (state)
      IDLE: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
        req_d   = RESET_PC;
      end
      FETCH: begin
        if (redir) begin
          pc_d = tgt;
          if (imem_ready) req_d = tgt;
          else            state_d = DRAIN;
        end else if (imem_ready) begin
          if (accept) begin
            pc_d  = req_addr + 32'd4;
            req_d = req_addr + 32'd4;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d      = tgt;
          req_d     = tgt;
          buf_clear = 1'b1;
          state_d   = FETCH;
        end else if (accept) begin
          pc_d    = pc_buf + 32'd4;
          req_d   = pc_buf + 32'd4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // stale response is swallowed; resume at the latest target
        if (redir) pc_d = tgt;
        if (imem_ready) begin
          req_d   = pc_d;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = req_addr;
    PCOUT       = pc_buf;
    IR          = NOP;
    fetch_valid = 1'b0;
    fetch_busy  = 1'b0;
    unique case (state)
      IDLE: ;
      FETCH: begin
        imem_req = 1'b1;
        PCOUT    = req_addr;
        if (imem_ready) begin
          IR          = imem_rdata;
          fetch_valid = 1'b1;
        end else begin
          fetch_busy = 1'b1;
        end
      end
      HOLD: begin
        IR          = ir_buf;
        fetch_valid = 1'b1;
      end
      DRAIN: begin
        imem_req   = 1'b1;
        fetch_busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed test-plan cases plus random
// traffic checked every cycle against a behavioural model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EN = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PCOUT;
  logic [31:0] IR;
  logic        fetch_valid;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .EN         (EN),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCOUT      (PCOUT),
    .IR         (IR),
    .fetch_valid(fetch_valid),
    .fetch_busy (fetch_busy)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a << 8) ^ 32'h5A5A_0007;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic en, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    EN          = en;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = mem(imem_addr);
    #1;
  endtask

  // Behavioural model: what the stage is doing, not how it is encoded.
  bit          m_boot = 1'b1;
  bit          m_hold = 1'b0;
  bit          m_drain = 1'b0;
  logic [31:0] m_req = RESET_VECTOR;
  logic [31:0] m_next = RESET_VECTOR;
  logic [31:0] m_hir = NOP_INSTR;
  logic [31:0] m_hpc = RESET_VECTOR;
  bit          fetching, e_req, e_valid, e_busy, m_redir, m_acc;
  logic [31:0] e_ir, e_pc, m_tgt;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      m_boot  = 1'b1;
      m_hold  = 1'b0;
      m_drain = 1'b0;
      m_req   = RESET_VECTOR;
      m_next  = RESET_VECTOR;
    end else begin
      fetching = !m_boot && !m_hold && !m_drain;
      e_req    = fetching || m_drain;
      e_valid  = m_hold || (fetching && imem_ready);
      e_busy   = m_drain || (fetching && !imem_ready);
      e_ir     = m_hold ? m_hir : (e_valid ? mem(m_req) : NOP_INSTR);
      e_pc     = m_hold ? m_hpc : m_req;
      chk("m_req", 32'(imem_req), 32'(e_req));
      chk("m_valid", 32'(fetch_valid), 32'(e_valid));
      chk("m_busy", 32'(fetch_busy), 32'(e_busy));
      chk("m_ir", IR, e_ir);
      if (e_req) chk("m_addr", imem_addr, m_req);
      if (e_valid) chk("m_pcout", PCOUT, e_pc);
      m_tgt   = redirect_pc & ~32'h3;
      m_redir = EN && redirect;
      m_acc   = EN && !stall && !redirect;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_hold) begin
        if (m_redir) begin
          m_next = m_tgt; m_req = m_tgt; m_hold = 1'b0;
        end else if (m_acc) begin
          m_next = m_hpc + 4; m_req = m_hpc + 4; m_hold = 1'b0;
        end
      end else if (m_drain) begin
        if (m_redir) m_next = m_tgt;
        if (imem_ready) begin
          m_drain = 1'b0; m_req = m_next;
        end
      end else if (m_redir) begin
        m_next = m_tgt;
        if (imem_ready) m_req = m_tgt;
        else m_drain = 1'b1;
      end else if (imem_ready) begin
        if (m_acc) begin
          m_next = m_req + 4; m_req = m_req + 4;
        end else begin
          m_hold = 1'b1; m_hir = mem(m_req); m_hpc = m_req;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_pcout", PCOUT, 32'h0);
    chk("reset_ir", IR, 32'h13);
    chk("reset_busy", 32'(fetch_busy), 32'd0);

    cyc(1, 0, 0, 0, 1);
    chk("idle_req", 32'(imem_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, 1);
      chk("zw_req", 32'(imem_req), 32'd1);
      chk("zw_pcout", PCOUT, 32'(k * 4));
      chk("zw_valid", 32'(fetch_valid), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 0);
      chk("wait_busy", 32'(fetch_busy), 32'd1);
      chk("wait_ir", IR, 32'h13);
    end
    cyc(1, 0, 0, 0, 1);
    chk("wait_ir_done", IR, 32'h5A5A_1007);
    chk("wait_pcout", PCOUT, 32'h10);
    repeat (3) cyc(1, 0, 0, 0, 1);

    cyc(1, 1, 0, 0, 1);
    chk("st_pcout", PCOUT, 32'h20);
    cyc(1, 1, 0, 0, 0);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pcout", PCOUT, 32'h20);
    chk("hold_ir", IR, 32'h5A5A_2007);
    cyc(1, 0, 0, 0, 0);
    chk("hold_rel_valid", 32'(fetch_valid), 32'd1);
    cyc(1, 0, 0, 0, 1);
    chk("after_hold_addr", imem_addr, 32'h24);

    cyc(1, 0, 1, 32'h103, 1);
    chk("redir_src_addr", imem_addr, 32'h28);
    cyc(1, 0, 0, 0, 1);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_pcout", PCOUT, 32'h100);

    cyc(1, 0, 1, 32'h40, 1);
    cyc(1, 0, 1, 32'h200, 0);
    cyc(1, 0, 0, 0, 0);
    chk("drain_addr", imem_addr, 32'h40);
    chk("drain_busy", 32'(fetch_busy), 32'd1);
    cyc(1, 0, 0, 0, 1);
    chk("drain_drop", 32'(fetch_valid), 32'd0);
    cyc(1, 0, 0, 0, 1);
    chk("drain_next", imem_addr, 32'h200);

    cyc(1, 0, 1, 32'h50, 1);
    cyc(0, 0, 0, 0, 1);
    chk("en0_pcout", PCOUT, 32'h50);
    cyc(0, 0, 0, 0, 0);
    chk("en0_hold_req", 32'(imem_req), 32'd0);
    chk("en0_hold_pc", PCOUT, 32'h50);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("en1_next", imem_addr, 32'h54);

    cyc(1, 0, 1, 32'hFFFF_FFFF, 1);
    cyc(1, 0, 0, 0, 1);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0);
    chk("wrap_zero", imem_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        imem_ready = 1'b0;
      end else begin
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 9) < 6);
      end
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
